// File: rtl/sys_time_phase_aligner.sv
// ----------------------------------------------------------------------------
// sys_time_phase_aligner
//
// Bank of DEPTH free-running modulo counters kept phase-locked to a global
// system time. Every channel counts 0..cycle[i]-1 each clock. One shared,
// bit-serial remainder engine visits the channels round-robin and reloads
// each counter with (sys_time + phase[i]) mod cycle[i]. The dividend is
// pre-advanced by the engine's own latency, so the reloaded value is correct
// in the cycle it becomes visible.
//
// Each channel slot is exactly LAT = SYS_WIDTH+2 cycles: LOAD (1), CALC
// (SYS_WIDTH), APPLY (1). A full sweep therefore takes DEPTH*LAT cycles.
//
// Ports
//   clk        clock; sys_time advances by one per clock
//   rst_n      asynchronous active-low reset
//   sys_time   global system time
//   sync_en    enables the sync engine; when low, counters only free-run
//   cycle      per-channel period (values below 2 hold the counter at 0)
//   phase      per-channel offset (may exceed the period; reduced by the mod)
//   time_cnt   per-channel counter outputs
//   sync_done  one-cycle pulse after the last channel of a complete sweep
//   synced     high once a complete sweep has finished since enable
// ----------------------------------------------------------------------------
module sys_time_phase_aligner #(
    parameter int WIDTH     = 13,
    parameter int DEPTH     = 249,
    parameter int SYS_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SYS_WIDTH-1:0] sys_time,
    input  logic                 sync_en,
    input  logic [WIDTH-1:0]     cycle    [DEPTH],
    input  logic [WIDTH-1:0]     phase    [DEPTH],
    output logic [WIDTH-1:0]     time_cnt [DEPTH],
    output logic                 sync_done,
    output logic                 synced
);

    // Engine latency from the LOAD sample to the cycle the result is visible.
    localparam int LAT   = SYS_WIDTH + 2;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BIT_W = (SYS_WIDTH > 1) ? $clog2(SYS_WIDTH) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [BIT_W-1:0] TOP_BIT  = BIT_W'(SYS_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_APPLY
    } state_t;

    state_t state;
    state_t state_nxt;

    // Engine datapath
    logic [IDX_W-1:0]     idx;       // channel being serviced
    logic [SYS_WIDTH-1:0] dividend;  // shifted left one bit per CALC cycle
    logic [WIDTH-1:0]     d;         // period snapshot taken at LOAD
    logic [WIDTH:0]       r;         // partial remainder; one spare bit
    logic [BIT_W-1:0]     bit_cnt;   // dividend bits still to consume

    // Decoded controls
    logic load_en;
    logic calc_en;
    logic apply_en;
    logic apply_wr;   // APPLY that actually overwrites the counter
    logic sweep_end;  // APPLY of the last channel

    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] r_step;

    // ------------------------------------------------------------------------
    // Sync FSM: state register
    // ------------------------------------------------------------------------
    // NOTE: all clocked state is written with non-blocking assignments so every
    // register samples the values that were present before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Sync FSM: next state and control decode
    // ------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        calc_en   = 1'b0;
        apply_en  = 1'b0;

        if (!sync_en) begin
            // Abandon the slot at once; the pending result is never applied.
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state_nxt = S_LOAD;
                end
                S_LOAD: begin
                    load_en   = 1'b1;
                    state_nxt = S_CALC;
                end
                S_CALC: begin
                    calc_en = 1'b1;
                    if (bit_cnt == '0) begin
                        state_nxt = S_APPLY;
                    end
                end
                S_APPLY: begin
                    apply_en  = 1'b1;
                    state_nxt = S_LOAD;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // A period below 2 has no meaningful phase, and a period that changed
    // since LOAD makes the remainder stale; both leave the counter free-running.
    // The slot length is unaffected either way.
    assign apply_wr  = apply_en && (d >= WIDTH'(2)) && (cycle[idx] == d);
    assign sweep_end = apply_en && (idx == LAST_IDX);

    // One restoring-remainder step: bring in the next dividend bit (MSB first)
    // and subtract the divisor if it fits. r stays below d < 2^WIDTH between
    // steps, so the shifted value always fits in WIDTH+1 bits.
    assign r_shift = {r[WIDTH-1:0], dividend[SYS_WIDTH-1]};
    assign r_step  = (r_shift >= {1'b0, d}) ? (r_shift - {1'b0, d}) : r_shift;

    // ------------------------------------------------------------------------
    // Remainder engine datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            dividend <= '0;
            d        <= '0;
            r        <= '0;
            bit_cnt  <= '0;
        end else begin
            if (state == S_IDLE) begin
                idx <= '0;
            end else if (apply_en) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end

            if (load_en) begin
                // Pre-advance by LAT so the result matches sys_time + phase
                // in the cycle it lands in the counter.
                dividend <= sys_time + SYS_WIDTH'(LAT) + SYS_WIDTH'(phase[idx]);
                d        <= cycle[idx];
                r        <= '0;
                bit_cnt  <= TOP_BIT;
            end else if (calc_en) begin
                dividend <= dividend << 1;
                r        <= r_step;
                bit_cnt  <= bit_cnt - BIT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sweep status
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_done <= 1'b0;
            synced    <= 1'b0;
        end else begin
            sync_done <= sweep_end;
            if (!sync_en) begin
                synced <= 1'b0;
            end else if (sweep_end) begin
                synced <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Counter bank: free-run every cycle, overridden by the engine on APPLY
    // ------------------------------------------------------------------------
    // NOTE: the counter array is a bank of output registers rather than a RAM,
    // so it takes the asynchronous reset like any other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                time_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (apply_wr && (idx == IDX_W'(i))) begin
                    time_cnt[i] <= r[WIDTH-1:0];
                end else if ((cycle[i] < WIDTH'(2)) ||
                             (time_cnt[i] >= cycle[i] - WIDTH'(1))) begin
                    // >= rather than == so a shrinking period wraps at once.
                    time_cnt[i] <= '0;
                end else begin
                    time_cnt[i] <= time_cnt[i] + WIDTH'(1);
                end
            end
        end
    end

endmodule
